stack_ctrl_seq: RTL and testbench

Command sequencer driving the control inputs of the stack/TOS datapath block in the pamPy core. Accepts one high-level stack command per valid/ready handshake from the instruction decoder, and emits the multi-cycle control sequences (register loads, mux selects, TOS update, memory writes) that execute it. Tracks stack depth and rejects pushes on overflow and pops on underflow.

---
 rtl/stack_ctrl_seq_if.sv | 30 +++
 rtl/stack_ctrl_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_stack_ctrl_seq.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// stack_ctrl_seq_if
//   Command handshake between the instruction decoder and the stack command
//   sequencer. The decoder offers a command with CMD_VALID/CMD_OP/TOS_RESTORE.
//   The sequencer reports CMD_READY, a one-cycle DONE at completion, and ERR
//   alongside DONE when the command was rejected.
//
//   master : decoder side (drives the command, observes ready/done/err)
//   slave  : sequencer side
// ---------------------------------------------------------------------------
interface stack_ctrl_seq_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  CMD_VALID;
  logic [2:0]            CMD_OP;
  logic [ADDR_WIDTH-1:0] TOS_RESTORE;
  logic                  CMD_READY;
  logic                  DONE;
  logic                  ERR;

  modport master (
    output CMD_VALID, CMD_OP, TOS_RESTORE,
    input  CMD_READY, DONE, ERR
  );

  modport slave (
    input  CMD_VALID, CMD_OP, TOS_RESTORE,
    output CMD_READY, DONE, ERR
  );
endinterface

// File: rtl/stack_ctrl_seq.sv
// ---------------------------------------------------------------------------
// stack_ctrl_seq
//   Turns one high-level stack command per handshake into the multi-cycle
//   control sequence for the stack/TOS datapath. It tracks the element count,
//   and it rejects pushes when the stack is full and pops when it is empty.
//
// Ports
//   clk, reset            single clock; synchronous active-high reset
//   cmd (slave)           CMD_VALID/CMD_OP/TOS_RESTORE in; CMD_READY/DONE/ERR out
//   OVF_STICKY/UNF_STICKY set by a rejected push/pop, cleared only by reset
//   DEPTH                 current element count (slot 0 is never written)
//   SEL_MUX_STACK, CTRL_* , SEL_MUX_TOS, SEL_TOS_UPDATER, CTRL_STACK,
//   CTRL_MEM_EXT          datapath controls, decoded from registered state
// ---------------------------------------------------------------------------
module stack_ctrl_seq #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  stack_ctrl_seq_if.slave       cmd,
  output logic                  OVF_STICKY,
  output logic                  UNF_STICKY,
  output logic [ADDR_WIDTH-1:0] DEPTH,
  output logic [2:0]            SEL_MUX_STACK,
  output logic                  CTRL_REG_READ_STACK,
  output logic                  CTRL_REG_WRITE_STACK,
  output logic                  CTRL_REG_READ_MEM,
  output logic                  CTRL_REG_WRITE_MEM,
  output logic                  SEL_MUX_TOS,
  output logic                  CTRL_REG_TOS,
  output logic                  SEL_TOS_UPDATER,
  output logic                  CTRL_STACK,
  output logic                  CTRL_MEM_EXT
);

  typedef enum logic [2:0] {
    OP_PUSH_ALU  = 3'b000,
    OP_PUSH_MEM  = 3'b001,
    OP_PUSH_RET  = 3'b010,
    OP_PUSH_ARG  = 3'b011,
    OP_DUP       = 3'b100,
    OP_POP       = 3'b101,
    OP_STORE_MEM = 3'b110,
    OP_SET_TOS   = 3'b111
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_MEM_WAIT,
    S_MEM_CAP,
    S_RD_WAIT,
    S_RD_CAP,
    S_PUSH_LD,
    S_PUSH_WR,
    S_ST_WR,
    S_TOS_LD,
    S_RESP
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_ONE = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  op_e  in_op;
  logic in_is_push;
  logic in_is_pop;
  logic depth_full;
  logic depth_empty;

  assign in_op       = op_e'(cmd.CMD_OP);
  // The five push-class opcodes are exactly 000..100.
  assign in_is_push  = (cmd.CMD_OP <= 3'b100);
  assign in_is_pop   = (in_op == OP_POP) || (in_op == OP_STORE_MEM);
  // Usable depth is 2^ADDR_WIDTH-1, so "full" is the all-ones count.
  assign depth_full  = &depth_q;
  assign depth_empty = (depth_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_PUSH_ALU;
      err_q   <= 1'b0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Next-state logic. The depth counter moves in the same cycle that the
  // datapath updates TOS, so the two stay in lockstep.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd.CMD_VALID) begin
          op_d  = in_op;
          err_d = 1'b0;
          if (in_is_push && depth_full) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            ovf_d   = 1'b1;
          end else if (in_is_pop && depth_empty) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            unf_d   = 1'b1;
          end else begin
            unique case (in_op)
              OP_PUSH_ALU, OP_PUSH_RET, OP_PUSH_ARG: state_d = S_PUSH_LD;
              OP_PUSH_MEM:                           state_d = S_MEM_WAIT;
              OP_DUP, OP_POP, OP_STORE_MEM:          state_d = S_RD_WAIT;
              OP_SET_TOS:                            state_d = S_TOS_LD;
              default:                               state_d = S_IDLE;
            endcase
          end
        end
      end
      S_MEM_WAIT: state_d = S_MEM_CAP;
      S_MEM_CAP:  state_d = S_PUSH_LD;
      S_RD_WAIT:  state_d = S_RD_CAP;
      S_RD_CAP: begin
        if (op_q == OP_DUP) begin
          state_d = S_PUSH_LD;
        end else if (op_q == OP_STORE_MEM) begin
          state_d = S_ST_WR;
        end else begin
          state_d = S_RESP;
          depth_d = depth_q - DEPTH_ONE;
        end
      end
      S_PUSH_LD: begin
        state_d = S_PUSH_WR;
        depth_d = depth_q + DEPTH_ONE;
      end
      S_PUSH_WR: state_d = S_RESP;
      S_ST_WR: begin
        state_d = S_RESP;
        depth_d = depth_q - DEPTH_ONE;
      end
      S_TOS_LD: begin
        // The datapath loads TOS from TOS_RESTORE in this cycle; mirror it.
        state_d = S_RESP;
        depth_d = cmd.TOS_RESTORE;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: a function of registered state and the latched opcode only,
  // so nothing on the command inputs can reach a control combinationally.
  always_comb begin
    SEL_MUX_STACK        = 3'b000;
    CTRL_REG_READ_STACK  = 1'b0;
    CTRL_REG_WRITE_STACK = 1'b0;
    CTRL_REG_READ_MEM    = 1'b0;
    CTRL_REG_WRITE_MEM   = 1'b0;
    SEL_MUX_TOS          = 1'b0;
    CTRL_REG_TOS         = 1'b0;
    SEL_TOS_UPDATER      = 1'b0;
    CTRL_STACK           = 1'b0;
    CTRL_MEM_EXT         = 1'b0;

    unique case (state_q)
      S_PUSH_LD: begin
        // Opcodes 000..100 double as the stack-input mux select.
        SEL_MUX_STACK        = op_q;
        CTRL_REG_WRITE_STACK = 1'b1;
        CTRL_REG_TOS         = 1'b1;
      end
      S_PUSH_WR: CTRL_STACK        = 1'b1;
      S_MEM_CAP: CTRL_REG_READ_MEM = 1'b1;
      S_RD_CAP: begin
        if (op_q == OP_STORE_MEM) begin
          CTRL_REG_WRITE_MEM = 1'b1;
        end else begin
          CTRL_REG_READ_STACK = 1'b1;
          if (op_q == OP_POP) begin
            CTRL_REG_TOS    = 1'b1;
            SEL_TOS_UPDATER = 1'b1;
          end
        end
      end
      S_ST_WR: begin
        CTRL_MEM_EXT    = 1'b1;
        CTRL_REG_TOS    = 1'b1;
        SEL_TOS_UPDATER = 1'b1;
      end
      S_TOS_LD: begin
        SEL_MUX_TOS  = 1'b1;
        CTRL_REG_TOS = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd.CMD_READY = (state_q == S_IDLE);
  assign cmd.DONE      = (state_q == S_RESP);
  assign cmd.ERR       = (state_q == S_RESP) && err_q;
  assign DEPTH         = depth_q;
  assign OVF_STICKY    = ovf_q;
  assign UNF_STICKY    = unf_q;

endmodule

// File: tb/tb_stack_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_stack_ctrl_seq
//   Drives stack_ctrl_seq (ADDR_WIDTH=3, so both depth limits are reachable)
//   with directed and random commands. A command-level model tracks depth and
//   sticky flags and gives the expected per-cycle control trace for each
//   opcode.
// ---------------------------------------------------------------------------
module tb_stack_ctrl_seq;

  localparam int AW   = 3;
  localparam int FULL = (1 << AW) - 1;

  // Control vector layout: {sel_mux_stack[2:0], rd_stack, wr_stack, rd_mem,
  // wr_mem, mux_tos, reg_tos, tos_upd, ctrl_stack, mem_ext, done, err}
  localparam logic [13:0] V_RDS  = 14'h0400;
  localparam logic [13:0] V_WRS  = 14'h0200;
  localparam logic [13:0] V_RDM  = 14'h0100;
  localparam logic [13:0] V_WRM  = 14'h0080;
  localparam logic [13:0] V_MTOS = 14'h0040;
  localparam logic [13:0] V_RTOS = 14'h0020;
  localparam logic [13:0] V_UPD  = 14'h0010;
  localparam logic [13:0] V_CST  = 14'h0008;
  localparam logic [13:0] V_MEXT = 14'h0004;
  localparam logic [13:0] V_DONE = 14'h0002;
  localparam logic [13:0] V_ERR  = 14'h0001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_ctrl_seq_if #(.ADDR_WIDTH(AW)) cmd_if ();

  logic          OVF_STICKY, UNF_STICKY;
  logic [AW-1:0] DEPTH;
  logic [2:0]    SEL_MUX_STACK;
  logic          CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK;
  logic          CTRL_REG_READ_MEM, CTRL_REG_WRITE_MEM;
  logic          SEL_MUX_TOS, CTRL_REG_TOS, SEL_TOS_UPDATER;
  logic          CTRL_STACK, CTRL_MEM_EXT;

  stack_ctrl_seq #(.ADDR_WIDTH(AW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .cmd                  (cmd_if),
    .OVF_STICKY           (OVF_STICKY),
    .UNF_STICKY           (UNF_STICKY),
    .DEPTH                (DEPTH),
    .SEL_MUX_STACK        (SEL_MUX_STACK),
    .CTRL_REG_READ_STACK  (CTRL_REG_READ_STACK),
    .CTRL_REG_WRITE_STACK (CTRL_REG_WRITE_STACK),
    .CTRL_REG_READ_MEM    (CTRL_REG_READ_MEM),
    .CTRL_REG_WRITE_MEM   (CTRL_REG_WRITE_MEM),
    .SEL_MUX_TOS          (SEL_MUX_TOS),
    .CTRL_REG_TOS         (CTRL_REG_TOS),
    .SEL_TOS_UPDATER      (SEL_TOS_UPDATER),
    .CTRL_STACK           (CTRL_STACK),
    .CTRL_MEM_EXT         (CTRL_MEM_EXT)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Command-level model state
  int m_depth;
  bit m_ovf;
  bit m_unf;

  function automatic logic [13:0] obs();
    return {SEL_MUX_STACK, CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK,
            CTRL_REG_READ_MEM, CTRL_REG_WRITE_MEM, SEL_MUX_TOS, CTRL_REG_TOS,
            SEL_TOS_UPDATER, CTRL_STACK, CTRL_MEM_EXT, cmd_if.DONE, cmd_if.ERR};
  endfunction

  function automatic bit is_rejected(input logic [2:0] op);
    return ((op <= 3'd4) && (m_depth == FULL)) ||
           ((op == 3'd5 || op == 3'd6) && (m_depth == 0));
  endfunction

  // Expected control trace, one entry per cycle after the accept edge.
  task automatic expect_seq(input logic [2:0] op, input bit rej,
                            output logic [13:0] seq [6], output int lat);
    logic [13:0] push_ld;
    push_ld = {op, 11'b0} | V_WRS | V_RTOS;
    for (int i = 0; i < 6; i++) seq[i] = '0;
    if (rej) begin
      seq[0] = V_DONE | V_ERR; lat = 1;
    end else begin
      case (op)
        3'd1: begin
          seq[1] = V_RDM; seq[2] = push_ld; seq[3] = V_CST; seq[4] = V_DONE; lat = 5;
        end
        3'd4: begin
          seq[1] = V_RDS; seq[2] = push_ld; seq[3] = V_CST; seq[4] = V_DONE; lat = 5;
        end
        3'd5: begin
          seq[1] = V_RDS | V_RTOS | V_UPD; seq[2] = V_DONE; lat = 3;
        end
        3'd6: begin
          seq[1] = V_WRM; seq[2] = V_MEXT | V_RTOS | V_UPD; seq[3] = V_DONE; lat = 4;
        end
        3'd7: begin
          seq[0] = V_MTOS | V_RTOS; seq[1] = V_DONE; lat = 2;
        end
        default: begin
          seq[0] = push_ld; seq[1] = V_CST; seq[2] = V_DONE; lat = 3;
        end
      endcase
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    cmd_if.CMD_VALID = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    m_depth = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Issue one command and compare the full per-cycle control trace, then the
  // post-command IDLE state, depth and sticky flags against the model.
  task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] tos,
                         input bit hold, input string tag);
    logic [13:0] seq [6];
    int lat, w;
    bit rej;
    logic [AW-1:0] exp_d;
    w = 0;
    @(negedge clk);
    while (cmd_if.CMD_READY !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (cmd_if.CMD_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_timeout: ready=%b want 1", tag, cmd_if.CMD_READY);
      return;
    end
    rej = is_rejected(op);
    expect_seq(op, rej, seq, lat);
    cmd_if.CMD_VALID   = 1'b1;
    cmd_if.CMD_OP      = op;
    cmd_if.TOS_RESTORE = tos;
    @(posedge clk);
    for (int n = 0; n < lat; n++) begin
      @(negedge clk);
      if (!hold) begin
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_OP    = 3'($urandom);
      end
      n_cmp++;
      if (obs() !== seq[n]) begin
        n_bad++;
        $display("FAIL %s ctrl op%0d cyc%0d: got %h want %h", tag, op, n + 1, obs(), seq[n]);
      end
      n_cmp++;
      if (cmd_if.CMD_READY !== 1'b0) begin
        n_bad++;
        $display("FAIL %s busy_ready op%0d cyc%0d: got %b want 0", tag, op, n + 1, cmd_if.CMD_READY);
      end
    end
    if (rej) begin
      if (op <= 3'd4) m_ovf = 1'b1;
      else            m_unf = 1'b1;
    end else if (op <= 3'd4) m_depth++;
    else if (op == 3'd7)     m_depth = int'(tos);
    else                     m_depth--;
    exp_d = m_depth[AW-1:0];
    @(negedge clk);
    cmd_if.CMD_VALID = 1'b0;
    n_cmp++;
    if (cmd_if.CMD_READY !== 1'b1 || obs() !== 14'h0) begin
      n_bad++;
      $display("FAIL %s after op%0d: ready=%b ctrl=%h want ready=1 ctrl=0000", tag, op, cmd_if.CMD_READY, obs());
    end
    n_cmp++;
    if (DEPTH !== exp_d) begin
      n_bad++;
      $display("FAIL %s depth op%0d: got %0d want %0d", tag, op, DEPTH, exp_d);
    end
    n_cmp++;
    if (OVF_STICKY !== m_ovf || UNF_STICKY !== m_unf) begin
      n_bad++;
      $display("FAIL %s sticky op%0d: got ovf=%b unf=%b want ovf=%b unf=%b", tag, op, OVF_STICKY, UNF_STICKY, m_ovf, m_unf);
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
    @(negedge clk);
    n_cmp++;
    if (cmd_if.CMD_READY !== 1'b1 || obs() !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b ctrl=%h want ready=1 ctrl=0000", cmd_if.CMD_READY, obs());
    end
    n_cmp++;
    if (DEPTH !== '0 || OVF_STICKY !== 1'b0 || UNF_STICKY !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_status: depth=%0d ovf=%b unf=%b want 0 0 0", DEPTH, OVF_STICKY, UNF_STICKY);
    end
  endtask

  task automatic test_push();
    run_cmd(3'd0, '0, 1'b0, "push_alu");
    run_cmd(3'd1, '0, 1'b0, "push_mem");
  endtask

  task automatic test_underflow_store();
    apply_reset(2);
    run_cmd(3'd5, '0, 1'b0, "pop_empty");
    run_cmd(3'd6, '0, 1'b0, "store_empty");
    run_cmd(3'd2, '0, 1'b0, "push_ret");
    run_cmd(3'd3, '0, 1'b0, "push_arg");
    run_cmd(3'd6, '0, 1'b0, "store_mem");
    run_cmd(3'd5, '0, 1'b0, "pop");
  endtask

  task automatic test_overflow();
    apply_reset(2);
    for (int i = 0; i < FULL; i++) run_cmd(3'(i % 4), '0, 1'b0, "fill");
    run_cmd(3'd0, '0, 1'b0, "push_full");
    run_cmd(3'd4, '0, 1'b0, "dup_full");
    run_cmd(3'd1, '0, 1'b0, "push_mem_full");
  endtask

  task automatic test_set_tos();
    run_cmd(3'd7, 3'd5, 1'b1, "set_tos_hold");
    run_cmd(3'd4, '0, 1'b1, "dup_hold");
    run_cmd(3'd7, 3'd0, 1'b0, "set_tos_zero");
    run_cmd(3'd7, 3'(FULL), 1'b0, "set_tos_full");
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++)
      run_cmd(3'($urandom_range(0, 7)), AW'($urandom), 1'($urandom), "random");
  endtask

  // Reset lands while a DUP is in PUSH_WR: everything must drop next cycle.
  task automatic test_reset_mid();
    logic [13:0] seq [6];
    int lat;
    run_cmd(3'd7, 3'd0, 1'b0, "mid_prep0");
    run_cmd(3'd5, '0, 1'b0, "mid_prep_unf");
    run_cmd(3'd7, 3'(FULL), 1'b0, "mid_prep7");
    run_cmd(3'd0, '0, 1'b0, "mid_prep_ovf");
    run_cmd(3'd7, 3'd2, 1'b0, "mid_prep2");
    expect_seq(3'd4, 1'b0, seq, lat);
    @(negedge clk);
    cmd_if.CMD_VALID = 1'b1;
    cmd_if.CMD_OP    = 3'd4;
    @(posedge clk);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      cmd_if.CMD_VALID = 1'b0;
      n_cmp++;
      if (obs() !== seq[n]) begin
        n_bad++;
        $display("FAIL reset_mid ctrl cyc%0d: got %h want %h", n + 1, obs(), seq[n]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs() !== 14'h0 || DEPTH !== '0) begin
      n_bad++;
      $display("FAIL reset_mid abort: ctrl=%h depth=%0d want 0000 0", obs(), DEPTH);
    end
    n_cmp++;
    if (OVF_STICKY !== 1'b0 || UNF_STICKY !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid sticky: ovf=%b unf=%b want 0 0", OVF_STICKY, UNF_STICKY);
    end
    reset = 1'b0;
    m_depth = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_if.CMD_READY !== 1'b1 || obs() !== 14'h0 || DEPTH !== '0) begin
      n_bad++;
      $display("FAIL reset_mid release: ready=%b ctrl=%h depth=%0d want 1 0000 0", cmd_if.CMD_READY, obs(), DEPTH);
    end
    run_cmd(3'd0, '0, 1'b0, "post_reset_push");
  endtask

  initial begin
    reset = 1'b1;
    cmd_if.CMD_VALID   = 1'b0;
    cmd_if.CMD_OP      = 3'd0;
    cmd_if.TOS_RESTORE = '0;
    m_depth = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    test_reset();
    test_push();
    test_underflow_store();
    test_overflow();
    test_set_tos();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
